// File: rtl/thermo_code_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : thermo_code_gen_if
// Description : Request/response bundle for the thermometer-code stimulus
//               generator. The master side issues single-shot or sweep
//               requests and observes the emulated FF column; the slave side
//               is the generator itself.
//
//   Request side (master -> slave)
//     bin_in       requested bin for a single shot
//     bin_valid    single-shot request strobe
//     sweep_start  launch a sweep over bins 0..NUM_FF-4
//     hold_cycles  cycles each pattern is held (0 behaves as 1)
//     bubble_en    inject a one-bit bubble two positions below the edge
//   Response side (slave -> master)
//     bin_ready     generator idle, a request is taken this cycle
//     pattern_out   emulated FF column snapshot
//     pattern_valid pattern_out carries a coded bin
//     expected_bin  bin the stop decoder must report for pattern_out
//     busy          generator not idle
//     sweep_done    single-cycle pulse on the final gap of a sweep
//
// Revision    : 1.0 - initial release
// ============================================================================
interface thermo_code_gen_if #(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8,
    parameter int HOLD_W    = 8
);
    logic [BITS_DECO-1:0] bin_in;
    logic                 bin_valid;
    logic                 bin_ready;
    logic                 sweep_start;
    logic [HOLD_W-1:0]    hold_cycles;
    logic                 bubble_en;
    logic [NUM_FF-1:0]    pattern_out;
    logic                 pattern_valid;
    logic [BITS_DECO-1:0] expected_bin;
    logic                 busy;
    logic                 sweep_done;

    modport master (
        output bin_in,
        output bin_valid,
        output sweep_start,
        output hold_cycles,
        output bubble_en,
        input  bin_ready,
        input  pattern_out,
        input  pattern_valid,
        input  expected_bin,
        input  busy,
        input  sweep_done
    );

    modport slave (
        input  bin_in,
        input  bin_valid,
        input  sweep_start,
        input  hold_cycles,
        input  bubble_en,
        output bin_ready,
        output pattern_out,
        output pattern_valid,
        output expected_bin,
        output busy,
        output sweep_done
    );
endinterface
`default_nettype wire

// File: rtl/thermo_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : thermo_code_gen
// Description : Thermometer-code stimulus generator standing in for the live
//               carry-chain capture in front of the TDC stop decoder. For a
//               bin b in 1..NUM_FF-4 the column has bits [b-1:0] clear and
//               bits [NUM_FF-1:b] set; bin 0 is an all-zero column (no edge).
//               An optional bubble sets bit b-2, which the decoder must
//               reject because it looks for a zero followed by four ones.
//               Each pattern is held for max(hold_cycles,1) cycles and is
//               followed by one all-zero gap cycle. A sweep walks every bin
//               0..NUM_FF-4 with the hold and bubble settings captured at
//               launch.
//
//   Ports
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : thermo_code_gen_if.slave (request inputs, pattern outputs)
//
//   Parameters
//     NUM_FF    : emulated FF column width, at least 6
//     BITS_DECO : bin number width, 2**BITS_DECO > NUM_FF-4
//     HOLD_W    : hold-count width
//
// Revision    : 1.0 - initial release
// ============================================================================
module thermo_code_gen #(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8,
    parameter int HOLD_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    thermo_code_gen_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Highest bin that still leaves four ones above the edge.
    localparam logic [BITS_DECO-1:0] c_max_bin  = BITS_DECO'(NUM_FF - 4);
    localparam logic [BITS_DECO-1:0] c_bin_one  = BITS_DECO'(1);
    localparam logic [HOLD_W-1:0]    c_hold_one = HOLD_W'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [BITS_DECO-1:0] r_bin;       // bin currently presented
    logic [HOLD_W-1:0]    r_hold;      // hold count latched at accept
    logic                 r_bubble;    // bubble enable latched at accept
    logic                 r_sweep;     // a sweep is in progress
    logic [HOLD_W-1:0]    r_cnt;       // remaining DRIVE cycles minus one
    logic [NUM_FF-1:0]    r_pattern;
    logic                 r_pvalid;
    logic [BITS_DECO-1:0] r_expected;
    logic                 r_busy;
    logic                 r_done;

    logic [BITS_DECO-1:0] w_bin_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic                 w_bubble_nxt;
    logic                 w_sweep_nxt;
    logic [HOLD_W-1:0]    w_cnt_nxt;
    logic [NUM_FF-1:0]    w_pattern_nxt;
    logic                 w_pvalid_nxt;
    logic [BITS_DECO-1:0] w_expected_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    // sweep_start wins over a coincident bin_valid; the single-shot request
    // is simply not taken and must be held by the requester.
    logic w_is_idle;
    logic w_accept_sweep;
    logic w_accept_single;
    logic w_accept;

    assign w_is_idle       = (r_state == S_IDLE);
    assign w_accept_sweep  = w_is_idle && bus.sweep_start;
    assign w_accept_single = w_is_idle && !bus.sweep_start && bus.bin_valid;
    assign w_accept        = w_accept_sweep || w_accept_single;

    // Out-of-range single-shot requests collapse to bin 0 (no edge).
    logic [BITS_DECO-1:0] w_req_bin;
    assign w_req_bin = (bus.bin_in > c_max_bin) ? '0 : bus.bin_in;

    // ------------------------------------------------------------------------
    // Load values for the next DRIVE phase
    // ------------------------------------------------------------------------
    // In IDLE the settings come straight from the request; in GAP (next bin
    // of a sweep) they come from the values latched at sweep launch.
    logic [BITS_DECO-1:0] w_ld_bin;
    logic                 w_ld_bubble;
    logic [HOLD_W-1:0]    w_ld_hold;
    logic [HOLD_W-1:0]    w_ld_cnt;

    always_comb begin
        w_ld_bin    = r_bin + c_bin_one;
        w_ld_bubble = r_bubble;
        w_ld_hold   = r_hold;
        if (w_is_idle) begin
            w_ld_bin    = bus.sweep_start ? '0 : w_req_bin;
            w_ld_bubble = bus.bubble_en;
            w_ld_hold   = bus.hold_cycles;
        end
    end

    // A hold of zero behaves as one; the counter runs from H-1 down to 0.
    assign w_ld_cnt = (w_ld_hold == '0) ? '0 : (w_ld_hold - c_hold_one);

    // ------------------------------------------------------------------------
    // Thermometer pattern for w_ld_bin
    // ------------------------------------------------------------------------
    // Comparisons are done at 32 bits so the column index never truncates
    // when NUM_FF exceeds the bin width range.
    logic [31:0]       w_ld_bin32;
    logic              w_edge_present;
    logic              w_bubble_active;
    logic [NUM_FF-1:0] w_ld_pattern;

    assign w_ld_bin32      = 32'(w_ld_bin);
    assign w_edge_present  = (w_ld_bin != '0);
    // Bins 0 and 1 have no room for a bubble below the edge.
    assign w_bubble_active = w_ld_bubble && (w_ld_bin32 >= 32'd2);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FF; gi++) begin : g_col_bit
            localparam logic [31:0] c_idx     = 32'(gi);
            localparam logic [31:0] c_idx_p2  = 32'(gi + 2);
            assign w_ld_pattern[gi] =
                (w_edge_present && (c_idx >= w_ld_bin32)) ||
                (w_bubble_active && (c_idx_p2 == w_ld_bin32));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_hold_nxt     = r_hold;
        w_bubble_nxt   = r_bubble;
        w_sweep_nxt    = r_sweep;
        w_cnt_nxt      = r_cnt;
        w_pattern_nxt  = r_pattern;
        w_pvalid_nxt   = r_pvalid;
        w_expected_nxt = r_expected;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_pattern_nxt = '0;
                w_pvalid_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
                if (w_accept) begin
                    w_state_nxt    = S_DRIVE;
                    w_bin_nxt      = w_ld_bin;
                    w_hold_nxt     = w_ld_hold;
                    w_bubble_nxt   = w_ld_bubble;
                    w_sweep_nxt    = w_accept_sweep;
                    w_cnt_nxt      = w_ld_cnt;
                    w_pattern_nxt  = w_ld_pattern;
                    w_pvalid_nxt   = 1'b1;
                    w_expected_nxt = w_ld_bin;
                    w_busy_nxt     = 1'b1;
                end
            end

            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = S_GAP;
                    w_pattern_nxt = '0;
                    w_pvalid_nxt  = 1'b0;
                    // The gap after the last bin of a sweep carries the
                    // completion pulse.
                    w_done_nxt    = r_sweep && (r_bin == c_max_bin);
                end else begin
                    w_cnt_nxt = r_cnt - c_hold_one;
                end
            end

            S_GAP: begin
                if (r_sweep && (r_bin < c_max_bin)) begin
                    w_state_nxt    = S_DRIVE;
                    w_bin_nxt      = w_ld_bin;
                    w_cnt_nxt      = w_ld_cnt;
                    w_pattern_nxt  = w_ld_pattern;
                    w_pvalid_nxt   = 1'b1;
                    w_expected_nxt = w_ld_bin;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_sweep_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_sweep_nxt   = 1'b0;
                w_pattern_nxt = '0;
                w_pvalid_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_hold     <= '0;
            r_bubble   <= 1'b0;
            r_sweep    <= 1'b0;
            r_cnt      <= '0;
            r_pattern  <= '0;
            r_pvalid   <= 1'b0;
            r_expected <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_hold     <= w_hold_nxt;
            r_bubble   <= w_bubble_nxt;
            r_sweep    <= w_sweep_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pattern  <= w_pattern_nxt;
            r_pvalid   <= w_pvalid_nxt;
            r_expected <= w_expected_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // bin_ready is the only combinational output: decoded IDLE, forced low
    // while reset is held.
    assign bus.bin_ready     = w_is_idle && rst_n;
    assign bus.pattern_out   = r_pattern;
    assign bus.pattern_valid = r_pvalid;
    assign bus.expected_bin  = r_expected;
    assign bus.busy          = r_busy;
    assign bus.sweep_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_thermo_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_thermo_code_gen
// Description : Scoreboard bench for thermo_code_gen. Stimulus pushes the
//               expected (pattern, bin) of every pattern_valid cycle; an
//               independent monitor pops and compares on each valid cycle and
//               also runs a reference stop decoder on pattern_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thermo_code_gen;

    localparam int NUM_FF    = 64;
    localparam int BITS_DECO = 8;
    localparam int HOLD_W    = 8;
    localparam int MAX_BIN   = NUM_FF - 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    thermo_code_gen_if #(.NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO), .HOLD_W(HOLD_W)) bus ();

    thermo_code_gen #(.NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO), .HOLD_W(HOLD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_FF-1:0]    pat;
        logic [BITS_DECO-1:0] bin;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference stop decoder: lowest zero followed by four ones.
    function automatic logic [BITS_DECO-1:0] ref_decode(input logic [NUM_FF-1:0] p);
        for (int i = 0; i <= NUM_FF - 5; i++)
            if (!p[i] && p[i+1] && p[i+2] && p[i+3] && p[i+4])
                return BITS_DECO'(i + 1);
        return '0;
    endfunction

    function automatic logic [NUM_FF-1:0] model_pat(input int b, input bit bub);
        logic [NUM_FF-1:0] p;
        p = '0;
        if (b >= 1 && b <= MAX_BIN) begin
            for (int i = b; i < NUM_FF; i++) p[i] = 1'b1;
            if (bub && b >= 2) p[b-2] = 1'b1;
        end
        return p;
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && bus.pattern_valid) begin
            if (q.size() == 0) begin
                check("unexpected_pattern_valid", 64'(bus.expected_bin), 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pattern_out", bus.pattern_out, e.pat);
                check("expected_bin", 64'(bus.expected_bin), 64'(e.bin));
                check("decoder_vs_expected_bin", 64'(ref_decode(bus.pattern_out)), 64'(bus.expected_bin));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.bin_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic shot(input int b, input int h, input bit bub,
                        input logic [NUM_FF-1:0] epat, input logic [BITS_DECO-1:0] ebin);
        int hh;
        hh = (h == 0) ? 1 : h;
        wait_ready();
        for (int k = 0; k < hh; k++) q.push_back('{epat, ebin});
        bus.bin_in      = BITS_DECO'(b);
        bus.hold_cycles = HOLD_W'(h);
        bus.bubble_en   = bub;
        bus.bin_valid   = 1'b1;
        @(posedge clk);
        #1 bus.bin_valid = 1'b0;
        repeat (hh) @(negedge clk);
        check("last_drive_valid", 64'(bus.pattern_valid), 64'd1);
        @(negedge clk);
        check("gap_pattern", bus.pattern_out, 64'd0);
        check("gap_valid", 64'(bus.pattern_valid), 64'd0);
        check("gap_expected_held", 64'(bus.expected_bin), 64'(ebin));
        check("gap_busy", 64'(bus.busy), 64'd1);
        check("gap_not_ready", 64'(bus.bin_ready), 64'd0);
        @(negedge clk);
        check("ready_after_gap", 64'(bus.bin_ready), 64'd1);
    endtask

    task automatic sweep(input int h, input bit bub, input bit with_req);
        int hh;
        int done_at;
        int pulses;
        int ready_at;
        hh = (h == 0) ? 1 : h;
        done_at = -1;
        pulses = 0;
        ready_at = -1;
        wait_ready();
        for (int b = 0; b <= MAX_BIN; b++)
            for (int k = 0; k < hh; k++) q.push_back('{model_pat(b, bub), BITS_DECO'(b)});
        if (with_req)
            for (int k = 0; k < hh; k++) q.push_back('{64'hFFFF_FFFF_FFFF_FE00, BITS_DECO'(9)});
        bus.sweep_start = 1'b1;
        bus.bin_valid   = with_req;
        bus.bin_in      = BITS_DECO'(9);
        bus.hold_cycles = HOLD_W'(h);
        bus.bubble_en   = bub;
        @(posedge clk);
        // Changed settings must not affect the running sweep.
        #1 bus.sweep_start = 1'b0;
        bus.hold_cycles = HOLD_W'(h + 4);
        bus.bubble_en   = !bub;
        for (int k = 1; k <= (MAX_BIN + 1) * (hh + 1) + 20; k++) begin
            @(negedge clk);
            if (bus.sweep_done) begin
                pulses++;
                done_at = k;
            end
            if (bus.bin_ready) begin
                ready_at = k;
                break;
            end
        end
        check("sweep_done_pulses", 64'(pulses), 64'd1);
        check("sweep_done_cycle", 64'(done_at), 64'((MAX_BIN + 1) * (hh + 1)));
        check("sweep_ready_cycle", 64'(ready_at), 64'((MAX_BIN + 1) * (hh + 1) + 1));
        if (with_req) begin
            bus.hold_cycles = HOLD_W'(h);
            bus.bubble_en   = 1'b0;
            @(posedge clk);
            #1 bus.bin_valid = 1'b0;
        end
        wait_ready();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int valids;
        bus.bin_in      = '0;
        bus.bin_valid   = 1'b0;
        bus.sweep_start = 1'b0;
        bus.hold_cycles = '0;
        bus.bubble_en   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pattern", bus.pattern_out, 64'd0);
        check("rst_valid", 64'(bus.pattern_valid), 64'd0);
        check("rst_expected", 64'(bus.expected_bin), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.sweep_done), 64'd0);
        check("rst_ready_low", 64'(bus.bin_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'(bus.bin_ready), 64'd1);

        // Directed single shots
        shot(5,   3, 1'b0, 64'hFFFF_FFFF_FFFF_FFE0, 8'd5);
        shot(5,   3, 1'b1, 64'hFFFF_FFFF_FFFF_FFE8, 8'd5);
        shot(1,   2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'd1);
        shot(60,  2, 1'b0, 64'hF000_0000_0000_0000, 8'd60);
        shot(61,  2, 1'b0, 64'h0000_0000_0000_0000, 8'd0);
        shot(7,   0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'd7);
        shot(255, 1, 1'b1, 64'h0000_0000_0000_0000, 8'd0);
        shot(2,   1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 8'd2);
        shot(0,   1, 1'b1, 64'h0000_0000_0000_0000, 8'd0);

        // Sweeps: priority over a coincident request, then closed loop with bubble
        sweep(1, 1'b0, 1'b1);
        sweep(1, 1'b1, 1'b0);
        sweep(2, 1'b0, 1'b0);

        // Reset in the middle of a sweep, while bin 20 is driven
        wait_ready();
        for (int b = 0; b <= 20; b++) q.push_back('{model_pat(b, 1'b1), BITS_DECO'(b)});
        bus.sweep_start = 1'b1;
        bus.hold_cycles = HOLD_W'(1);
        bus.bubble_en   = 1'b1;
        @(posedge clk);
        #1 bus.sweep_start = 1'b0;
        repeat (41) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bins_seen", 64'(q.size()), 64'd0);
        check("midrst_pattern", bus.pattern_out, 64'd0);
        check("midrst_valid", 64'(bus.pattern_valid), 64'd0);
        check("midrst_expected", 64'(bus.expected_bin), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.sweep_done), 64'd0);
        check("midrst_ready_low", 64'(bus.bin_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_ready_release", 64'(bus.bin_ready), 64'd1);
        pulses = 0;
        valids = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (bus.sweep_done) pulses++;
            if (bus.pattern_valid) valids++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check("midrst_no_valid", 64'(valids), 64'd0);
        check("midrst_idle_ready", 64'(bus.bin_ready), 64'd1);

        // One more shot after the aborted sweep
        shot(33, 2, 1'b0, 64'hFFFF_FFFE_0000_0000, 8'd33);

        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
